mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: requester 0 is instruction fetch, requester 1 is data load/store.
- Round-robin arbitration. The winner's address, write data and write-enable are captured and held on the port until the memory acknowledges.
- Sits between the fetch/execute stages and the memory interface.
- Includes a timeout watchdog that aborts a transaction when the memory never acknowledges.

Parameters:
- n, constants::WORD_LENGTH, width of address and data words
- TIMEOUT, 16, cycles mem_req may stay high without mem_ack before abort (must be >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  fetch request; held high until ack0 or err0
- addr0  input  n  fetch address
- req1  input  1  data request; held high until ack1 or err1
- addr1  input  n  data address
- wdata1  input  n  store data
- we1  input  1  1 = store, 0 = load
- mem_req  output  1  memory port request
- mem_addr  output  n  memory port address
- mem_wdata  output  n  memory port write data
- mem_we  output  1  memory port write enable
- mem_ack  input  1  memory completion strobe; valid only while mem_req is high
- mem_rdata  input  n  read data, valid with mem_ack
- ack0  output  1  one-cycle completion pulse to fetch
- ack1  output  1  one-cycle completion pulse to data
- err0  output  1  one-cycle timeout pulse to fetch
- err1  output  1  one-cycle timeout pulse to data
- rdata  output  n  registered read data, valid with ack0/ack1

Behaviour:
- Reset:
  - Applied on any rising clk edge with rst=1, including mid-transaction.
  - State becomes IDLE.
  - mem_req, mem_we, ack0, ack1, err0, err1 = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
  - An in-flight transaction is dropped and no ack is issued.
- States: IDLE, BUSY0, BUSY1. Two-bit state encoding is defined in the package.
- IDLE:
  - Neither req asserted: remain in IDLE.
  - Exactly one req asserted: grant it.
  - Both asserted: grant the requester not equal to last_grant.
  - On grant, register the operands:
    - Requester 0: mem_addr ← addr0, mem_we ← 0, mem_wdata ← 0.
    - Requester 1: mem_addr ← addr1, mem_wdata ← wdata1, mem_we ← we1.
  - Also on grant: mem_req ← 1, counter ← 0, last_grant ← winner, state ← BUSYx.
- Latency: a req sampled in IDLE at edge N gives mem_req=1 after edge N. Operand selection uses two _mux2 instances.
- BUSYx:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - Requester inputs are ignored.
- BUSYx with mem_ack=1 at edge M:
  - rdata ← mem_rdata (also captured on stores; content is don't-care).
  - ackx=1 for exactly the cycle after M.
  - mem_req ← 0, state ← IDLE.
  - mem_ack=1 in the first cycle mem_req is high is legal and gives single-cycle memory.
- Next grant: the earliest next grant is decided at edge M+1, with mem_req high after M+1. This is one bubble cycle per transaction and is required behaviour.
- Timeout:
  - The counter increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT-1 and mem_ack=0: errx=1 for one cycle, mem_req ← 0, state ← IDLE, rdata unchanged.
  - mem_ack on that same edge takes precedence: normal ack, no err.
- Fairness: last_grant updates only on grant, not on completion or timeout.
- Requester misuse: a requester that drops req while BUSY does not affect the transaction; the ack is still issued.
- mem_ack while IDLE is ignored and has no output effect.
- ack0, ack1, err0, err1 are mutually exclusive; at most one is high in any cycle.
- Counter width: $clog2(TIMEOUT) bits; it never wraps because it is cleared on grant.

Decomposition:
- Shared constants package gets:
  - arb_state_t: IDLE=2'b00, BUSY0=2'b01, BUSY1=2'b10.
  - MEM_TIMEOUT_DEFAULT=16.
- WORD_LENGTH is already present in the package.
- Sub-modules:
  - Operand steering reuses the existing two-input _mux2 utility: one instance for the address, one for the write data (in0 tied to 0 for fetch).
  - No new sub-module is needed; the FSM, counter and output registers live in mem_port_arbiter.

Test Plan:
- Reset, then req0=1, addr0=0x0010:
  - mem_req=1, mem_addr=0x0010, mem_we=0 one cycle later.
  - mem_ack=1 with mem_rdata=0xBEEF → next cycle ack0=1, rdata=0xBEEF, mem_req=0.
- req0 and req1 held high continuously, memory acks every grant immediately: grants alternate 0,1,0,1; each ack is followed by one idle cycle with mem_req=0.
- Store request:
  - req1=1, we1=1, addr1=0x0020, wdata1=0x1234 gives mem_we=1, mem_wdata=0x1234.
  - Change addr1 to 0x0030 while BUSY1 → mem_addr stays 0x0020.
- Timeout with TIMEOUT=4, req1=1, mem_ack never asserted:
  - mem_req is high exactly 4 cycles, then err1 pulses once and ack1 stays 0.
  - A following req0 is granted.
  - Variant: mem_ack on the 4th cycle → ack1, no err1.
- Reset mid-transaction: assert rst during BUSY0, then assert mem_ack → no ack0; all outputs 0 the cycle after the reset edge; the next simultaneous request grants requester 0.
- mem_ack pulsed while IDLE with no requests: all outputs stay 0 and rdata is unchanged.

Source files
------------

// File: rtl/constants.sv
// rtl/constants.sv - shared word length, timeout default and arbiter state encoding
package constants;

   localparam int WORD_LENGTH         = 32;
   localparam int MEM_TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BUSY0 = 2'b01,
      BUSY1 = 2'b10
   } arb_state_t;

endpackage

// File: rtl/_mux2.sv
// rtl/_mux2.sv - two-input word multiplexer
module _mux2 #(
   parameter int n = 8
) (
   input  logic [n-1:0] in0,
   input  logic [n-1:0] in1,
   input  logic         sel,
   output logic [n-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin share of one memory port between fetch and data
module mem_port_arbiter
   import constants::*;
#(
   parameter int n       = WORD_LENGTH,
   parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic [n-1:0] addr0,
   input  logic         req1,
   input  logic [n-1:0] addr1,
   input  logic [n-1:0] wdata1,
   input  logic         we1,
   output logic         mem_req,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   output logic         mem_we,
   input  logic         mem_ack,
   input  logic [n-1:0] mem_rdata,
   output logic         ack0,
   output logic         ack1,
   output logic         err0,
   output logic         err1,
   output logic [n-1:0] rdata
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   arb_state_t    state;
   logic          last_grant;
   logic [CW-1:0] cnt;
   logic          any_req;
   logic          winner;
   logic [n-1:0]  sel_addr;
   logic [n-1:0]  sel_wdata;

   // On a tie the requester that did not win last time gets the port
   always_comb begin
      any_req = req0 | req1;
      winner  = (req0 & req1) ? ~last_grant : req1;
   end

   _mux2 #(.n(n)) u_addr_mux (
      .in0 (addr0),
      .in1 (addr1),
      .sel (winner),
      .out (sel_addr)
   );

   _mux2 #(.n(n)) u_wdata_mux (
      .in0 ({n{1'b0}}),
      .in1 (wdata1),
      .sel (winner),
      .out (sel_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata      <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  mem_req    <= 1'b1;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_we     <= winner & we1;
                  cnt        <= '0;
                  last_grant <= winner;
                  state      <= winner ? BUSY1 : BUSY0;
               end
            end
            BUSY0, BUSY1: begin
               // An ack on the final watchdog cycle still completes normally
               if (mem_ack) begin
                  rdata   <= mem_rdata;
                  ack0    <= (state == BUSY0);
                  ack1    <= (state == BUSY1);
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  err0    <= (state == BUSY0);
                  err1    <= (state == BUSY1);
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import constants::*;

   localparam int N  = WORD_LENGTH;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0, req1, we1, mem_ack;
   logic [N-1:0] addr0, addr1, wdata1, mem_rdata;
   logic         mem_req, mem_we, ack0, ack1, err0, err1;
   logic [N-1:0] mem_addr, mem_wdata, rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.n(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata)
   );

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Transaction-level reference: who owns the port and how many cycles it has been requested
   int           owner = -1;
   int           pref  = 0;
   int           age   = 0;
   int           m_w;
   logic         e_req, e_we, e_ack0, e_ack1, e_err0, e_err1;
   logic [N-1:0] e_addr, e_wdata, e_rdata;

   always @(posedge clk) begin
      e_ack0 = 1'b0; e_ack1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      if (rst) begin
         owner = -1; pref = 0; age = 0;
         e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else if (owner < 0) begin
         if (req0 || req1) begin
            m_w     = (req0 && req1) ? pref : (req1 ? 1 : 0);
            pref    = 1 - m_w;
            owner   = m_w;
            age     = 0;
            e_req   = 1'b1;
            e_addr  = (m_w == 1) ? addr1 : addr0;
            e_wdata = (m_w == 1) ? wdata1 : '0;
            e_we    = (m_w == 1) ? we1 : 1'b0;
         end
      end else begin
         age = age + 1;
         if (mem_ack) begin
            e_rdata = mem_rdata;
            if (owner == 0) e_ack0 = 1'b1; else e_ack1 = 1'b1;
            e_req = 1'b0;
            owner = -1;
         end else if (age == TO) begin
            if (owner == 0) e_err0 = 1'b1; else e_err1 = 1'b1;
            e_req = 1'b0;
            owner = -1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mem_req",   mem_req,   e_req);
         chk("mem_addr",  mem_addr,  e_addr);
         chk("mem_wdata", mem_wdata, e_wdata);
         chk("mem_we",    mem_we,    e_we);
         chk("ack0",      ack0,      e_ack0);
         chk("ack1",      ack1,      e_ack1);
         chk("err0",      err0,      e_err0);
         chk("err1",      err1,      e_err1);
         chk("rdata",     rdata,     e_rdata);
         chk("pulse_excl", 64'(int'(ack0) + int'(ack1) + int'(err0) + int'(err1) <= 1), 64'd1);
      end
   end

   int  hi, errs, acks, ack_pct;
   bit  done;

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; mem_ack = 1'b0;
      addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
      step();
      step();
      cmp_en = 1'b1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_mem_addr", mem_addr, '0);

      // single fetch
      rst = 1'b0; req0 = 1'b1; addr0 = 32'h0010;
      step();
      chk("f_req", mem_req, 1'b1);
      chk("f_addr", mem_addr, 32'h0010);
      chk("f_we", mem_we, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'hBEEF;
      step();
      chk("f_ack0", ack0, 1'b1);
      chk("f_rdata", rdata, 32'hBEEF);
      chk("f_req_low", mem_req, 1'b0);
      req0 = 1'b0; mem_ack = 1'b0;
      step();

      // both requesters held, immediate acks: grants alternate with a bubble
      rst = 1'b1;
      step();
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0100; addr1 = 32'h0200;
      we1 = 1'b0; wdata1 = 32'h55; mem_ack = 1'b1; mem_rdata = 32'hA0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_req", mem_req, 1'b1);
         chk("rr_addr", mem_addr, (i % 2 == 1) ? 32'h0200 : 32'h0100);
         step();
         chk("rr_ack", (i % 2 == 1) ? ack1 : ack0, 1'b1);
         chk("rr_bubble", mem_req, 1'b0);
      end
      req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
      step();

      // store, operand hold, then timeout
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0020; wdata1 = 32'h1234;
      step();
      chk("st_we", mem_we, 1'b1);
      chk("st_wdata", mem_wdata, 32'h1234);
      chk("st_addr", mem_addr, 32'h0020);
      addr1 = 32'h0030;
      hi = 1; errs = 0; acks = 0; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         step();
         if (mem_req) begin
            hi++;
            chk("st_hold_addr", mem_addr, 32'h0020);
         end
         if (err1) begin
            errs++;
            req1 = 1'b0;
         end
         if (ack1) acks++;
         if (!mem_req) done = 1'b1;
      end
      chk("to_done", done, 1'b1);
      chk("to_high_cycles", hi, TO);
      chk("to_err1", errs, 1);
      chk("to_no_ack1", acks, 0);
      req0 = 1'b1; addr0 = 32'h0040;
      step();
      chk("to_err1_once", err1, 1'b0);
      chk("to_next_grant", mem_addr, 32'h0040);
      mem_ack = 1'b1; mem_rdata = 32'h4444;
      step();
      chk("to_next_ack0", ack0, 1'b1);
      req0 = 1'b0; mem_ack = 1'b0;
      step();

      // ack on the last watchdog cycle wins over the timeout
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0060;
      step();
      step();
      step();
      step();
      chk("late_req", mem_req, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h6666;
      step();
      chk("late_ack1", ack1, 1'b1);
      chk("late_no_err1", err1, 1'b0);
      chk("late_rdata", rdata, 32'h6666);
      req1 = 1'b0; mem_ack = 1'b0;
      step();

      // reset during BUSY0 drops the transaction
      req0 = 1'b1; addr0 = 32'h0050;
      step();
      chk("mr_busy", mem_req, 1'b1);
      rst = 1'b1; req0 = 1'b0;
      step();
      chk("mr_req", mem_req, 1'b0);
      chk("mr_addr", mem_addr, '0);
      chk("mr_rdata", rdata, '0);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h9999;
      step();
      chk("mr_no_ack0", ack0, 1'b0);
      chk("mr_rdata_kept", rdata, '0);
      mem_ack = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0070; addr1 = 32'h0080;
      step();
      chk("mr_tie_to_0", mem_addr, 32'h0070);
      req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777;
      step();
      chk("mr_ack0", ack0, 1'b1);

      // ack while idle is ignored
      mem_rdata = 32'hDEAD;
      step();
      step();
      chk("idle_req", mem_req, 1'b0);
      chk("idle_ack", ack0 | ack1, 1'b0);
      chk("idle_rdata", rdata, 32'h7777);
      mem_ack = 1'b0;
      step();

      // randomized traffic with varying memory responsiveness
      for (int c = 0; c < 3000; c++) begin
         ack_pct = ((c / 500) % 3 == 0) ? 50 : (((c / 500) % 3 == 1) ? 15 : 3);
         rst = ($urandom_range(0, 99) == 0);
         if (req0 && (ack0 || err0)) req0 = 1'b0;
         else if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; addr0 = $urandom;
         end else if (req0 && $urandom_range(0, 39) == 0) req0 = 1'b0;
         if (req0 && $urandom_range(0, 9) == 0) addr0 = $urandom;
         if (req1 && (ack1 || err1)) req1 = 1'b0;
         else if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; addr1 = $urandom; wdata1 = $urandom; we1 = $urandom_range(0, 1) == 1;
         end else if (req1 && $urandom_range(0, 39) == 0) req1 = 1'b0;
         if (req1 && $urandom_range(0, 9) == 0) begin
            addr1 = $urandom; wdata1 = $urandom;
         end
         mem_ack   = ($urandom_range(0, 99) < ack_pct);
         mem_rdata = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
